// File: rtl/pr_queue_dispatcher_pkg.sv
// pr_queue_dispatcher_pkg: shared PR request types, error codes and dispatcher states
package pr_queue_dispatcher_pkg;
  localparam int NUM_SLOTS = 16;
  localparam int NUM_OUS = 8;
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int OU_W = $clog2(NUM_OUS);
  typedef struct packed {
    logic [SLOT_W-1:0] grid_slot;
    logic [OU_W-1:0] ou_id;
  } pr_queue_inputs_t;
  typedef enum logic [1:0] {PR_ERR_NONE, PR_ERR_CTRL, PR_ERR_TIMEOUT} pr_error_code_t;
  typedef enum logic [1:0] {PR_IDLE, PR_REQ, PR_WAIT} pr_dispatch_state_t;
  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [SLOT_W-1:0] s);
    return NUM_SLOTS'(1) << s;
  endfunction
endpackage

// File: rtl/pr_request_fifo.sv
// pr_request_fifo: register FIFO of PR requests exposing per-entry slots for busy retention
module pr_request_fifo
  import pr_queue_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  pr_queue_inputs_t               push_data,
  output pr_queue_inputs_t               head,
  output logic                           full,
  output logic                           empty,
  output logic                           avail,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [DEPTH-1:0][SLOT_W-1:0]   ent_slot
);
  pr_queue_inputs_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_n;
  logic do_push, do_pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push & !full & !flush;
  assign do_pop = pop & !empty & !flush;
  assign count_n = flush ? '0 : count + CNT_W'(do_push) - CNT_W'(do_pop);
  always_comb begin
    logic [PTR_W-1:0] off;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      ent_valid[i] = {1'b0, off} < count;
      ent_slot[i] = mem[i].grid_slot;
    end
  end
  // avail only counts entries that have sat in the FIFO for a full cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      avail <= 1'b0;
    end else begin
      rd_ptr <= flush ? '0 : rd_ptr + PTR_W'(do_pop);
      wr_ptr <= flush ? '0 : wr_ptr + PTR_W'(do_push);
      count <= count_n;
      avail <= count_n > CNT_W'(do_push);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pr_queue_dispatcher.sv
// pr_queue_dispatcher: buffers PR requests and dispatches them over req/ack/done with a slot busy map
module pr_queue_dispatcher
  import pr_queue_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  pr_queue_inputs_t      enq_packet,
  input  logic                  flush,
  output logic                  pr_req,
  output logic [SLOT_W-1:0]     pr_grid_slot,
  output logic [OU_W-1:0]       pr_ou_id,
  input  logic                  pr_ack,
  input  logic                  pr_done,
  input  logic                  pr_error,
  output logic [NUM_SLOTS-1:0]  slot_busy,
  output logic [CNT_W-1:0]      queue_count,
  output logic                  dispatcher_idle,
  output logic                  err_valid,
  output pr_error_code_t        err_code,
  output logic [SLOT_W-1:0]     err_slot
);
  pr_dispatch_state_t state, state_n;
  pr_error_code_t code_n;
  pr_queue_inputs_t head;
  logic full, empty, avail, push, pop, complete, fail, req_n;
  logic [SLOT_W-1:0] slot_n;
  logic [OU_W-1:0] ou_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0][SLOT_W-1:0] ent_slot;
  logic [NUM_SLOTS-1:0] queued, busy_n;
  assign enq_ready = !full & !flush;
  assign push = enq_valid & enq_ready;
  assign dispatcher_idle = state == PR_IDLE && empty;
  pr_request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .push_data(enq_packet),
    .head(head), .full(full), .empty(empty), .avail(avail), .count(queue_count),
    .ent_valid(ent_valid), .ent_slot(ent_slot)
  );
  // busy = every slot still queued after this edge, plus the in-flight one, plus a new arrival
  always_comb begin
    queued = '0;
    for (int i = 0; i < DEPTH; i++) queued = queued | (ent_valid[i] ? slot_mask(ent_slot[i]) : '0);
    busy_n = (push ? slot_mask(enq_packet.grid_slot) : '0) | (flush ? '0 : queued)
           | (state != PR_IDLE && !complete ? slot_mask(pr_grid_slot) : '0);
  end
  always_comb begin
    state_n = state;
    req_n = pr_req;
    slot_n = pr_grid_slot;
    ou_n = pr_ou_id;
    tcnt_n = tcnt;
    pop = 1'b0;
    complete = 1'b0;
    fail = 1'b0;
    case (state)
      PR_IDLE: if (avail && !flush) begin
        pop = 1'b1;
        req_n = 1'b1;
        slot_n = head.grid_slot;
        ou_n = head.ou_id;
        state_n = PR_REQ;
      end
      PR_REQ: begin
        complete = pr_ack & (pr_done | pr_error);
        fail = pr_ack & pr_error;
        if (pr_ack) begin
          req_n = 1'b0;
          tcnt_n = '0;
          state_n = complete ? PR_IDLE : PR_WAIT;
        end
      end
      PR_WAIT: begin
        tcnt_n = tcnt + 1'b1;
        fail = pr_error | (!pr_done & tcnt == TW'(TIMEOUT_CYCLES - 1));
        complete = fail | pr_done;
        state_n = complete ? PR_IDLE : PR_WAIT;
      end
      default: state_n = PR_IDLE;
    endcase
    code_n = fail ? (pr_error ? PR_ERR_CTRL : PR_ERR_TIMEOUT) : err_code;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PR_IDLE;
      pr_req <= 1'b0;
      pr_grid_slot <= '0;
      pr_ou_id <= '0;
      tcnt <= '0;
      slot_busy <= '0;
      err_valid <= 1'b0;
      err_code <= PR_ERR_NONE;
      err_slot <= '0;
    end else begin
      state <= state_n;
      pr_req <= req_n;
      pr_grid_slot <= slot_n;
      pr_ou_id <= ou_n;
      tcnt <= tcnt_n;
      slot_busy <= busy_n;
      err_valid <= fail;
      err_code <= code_n;
      err_slot <= fail ? pr_grid_slot : err_slot;
    end
  end
endmodule

// File: tb/tb_pr_queue_dispatcher.sv
// tb_pr_queue_dispatcher: directed and random stimulus checked against a transaction-level model
module tb_pr_queue_dispatcher;
  import pr_queue_dispatcher_pkg::*;
  localparam int DEPTH = 4;
  localparam int TMO = 16;
  typedef struct {
    pr_queue_inputs_t p;
    int t;
  } ment_t;
  logic clk = 0, rst = 1;
  logic enq_valid = 0, enq_ready, flush = 0, pr_req, pr_ack = 0, pr_done = 0, pr_error = 0;
  logic dispatcher_idle, err_valid;
  pr_queue_inputs_t enq_packet = '0;
  logic [SLOT_W-1:0] pr_grid_slot, err_slot;
  logic [OU_W-1:0] pr_ou_id;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [$clog2(DEPTH+1)-1:0] queue_count;
  pr_error_code_t err_code;
  int checks = 0, errors = 0, cyc = 0;
  ment_t mq[$];
  bit m_inf, m_acked, m_errv;
  int m_wcnt;
  logic [SLOT_W-1:0] m_slot, m_eslot;
  logic [OU_W-1:0] m_ou;
  pr_error_code_t m_code;

  pr_queue_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_packet(enq_packet),
    .flush(flush), .pr_req(pr_req), .pr_grid_slot(pr_grid_slot), .pr_ou_id(pr_ou_id),
    .pr_ack(pr_ack), .pr_done(pr_done), .pr_error(pr_error), .slot_busy(slot_busy),
    .queue_count(queue_count), .dispatcher_idle(dispatcher_idle), .err_valid(err_valid),
    .err_code(err_code), .err_slot(err_slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_SLOTS-1:0] m_busy();
    logic [NUM_SLOTS-1:0] b = '0;
    foreach (mq[i]) b[mq[i].p.grid_slot] = 1'b1;
    if (m_inf) b[m_slot] = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_inf = 0; m_acked = 0; m_errv = 0; m_wcnt = 0;
    m_slot = '0; m_ou = '0; m_eslot = '0; m_code = PR_ERR_NONE;
  endtask

  task automatic m_finish(input bit f, input pr_error_code_t c);
    m_inf = 0;
    if (f) begin m_errv = 1; m_code = c; m_eslot = m_slot; end
  endtask

  task automatic check_all();
    chk("pr_req", pr_req, m_inf && !m_acked);
    if (m_inf && !m_acked) begin
      chk("pr_grid_slot", pr_grid_slot, m_slot);
      chk("pr_ou_id", pr_ou_id, m_ou);
    end
    chk("slot_busy", slot_busy, m_busy());
    chk("queue_count", queue_count, mq.size());
    chk("dispatcher_idle", dispatcher_idle, !m_inf && mq.size() == 0);
    chk("err_valid", err_valid, m_errv);
    chk("err_code", err_code, m_code);
    chk("err_slot", err_slot, m_eslot);
  endtask

  // one clock: inputs are already driven; advance the model across the edge, then compare
  task automatic cycle();
    bit acc;
    ment_t e;
    #1 chk("enq_ready", enq_ready, mq.size() < DEPTH && !flush);
    acc = enq_valid && mq.size() < DEPTH && !flush;
    m_errv = 0;
    if (!m_inf) begin
      if (mq.size() > 0 && !flush && mq[0].t + 2 <= cyc) begin
        e = mq.pop_front();
        m_slot = e.p.grid_slot; m_ou = e.p.ou_id; m_inf = 1; m_acked = 0;
      end
    end else if (m_acked || pr_ack) begin
      if (pr_error) m_finish(1, PR_ERR_CTRL);
      else if (pr_done) m_finish(0, PR_ERR_NONE);
      else if (!m_acked) begin m_acked = 1; m_wcnt = 0; end
      else if (m_wcnt == TMO - 1) m_finish(1, PR_ERR_TIMEOUT);
      else m_wcnt++;
    end
    if (flush) mq.delete();
    if (acc) mq.push_back('{enq_packet, cyc});
    cyc++;
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!pr_req && k < 10) begin cycle(); k++; end
    chk("req_seen", pr_req, 1);
  endtask

  initial begin
    int n;
    bit quiet;
    m_reset();
    #1 check_all();
    @(negedge clk);
    rst = 0;
    // single request: latency two edges after the enqueue edge
    enq_valid = 1; enq_packet = '{grid_slot: 4'd5, ou_id: 3'd3};
    cycle();
    enq_valid = 0;
    cycle();
    chk("lat_e1", pr_req, 0);
    cycle();
    chk("lat_e2", pr_req, 1);
    chk("busy5", slot_busy, 16'h0020);
    repeat (3) cycle();
    pr_ack = 1; cycle(); pr_ack = 0;
    repeat (10) cycle();
    pr_done = 1; cycle(); pr_done = 0;
    chk("single_idle", dispatcher_idle, 1);
    chk("single_busy", slot_busy, 16'h0000);
    // timeout exactly TMO edges after the ack edge
    enq_valid = 1; enq_packet = '{grid_slot: 4'd9, ou_id: 3'd1};
    cycle(); enq_valid = 0;
    wait_req();
    pr_ack = 1; cycle(); pr_ack = 0;
    n = 0;
    while (!err_valid && n < 40) begin cycle(); n++; end
    chk("timeout_lat", n, TMO);
    chk("timeout_code", err_code, PR_ERR_TIMEOUT);
    chk("timeout_slot", err_slot, 9);
    // async reset in WAIT abandons the request silently
    enq_valid = 1; enq_packet = '{grid_slot: 4'd7, ou_id: 3'd2};
    cycle(); enq_valid = 0;
    wait_req();
    pr_ack = 1; cycle(); pr_ack = 0;
    repeat (3) cycle();
    #2 rst = 1;
    #1 m_reset();
    check_all();
    chk("rst_busy", slot_busy, 16'h0000);
    @(negedge clk);
    rst = 0; pr_done = 1;
    cycle(); pr_done = 0;
    cycle();
    // randomized traffic; alternating quiet windows force timeouts
    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 150) % 2) == 1;
      enq_valid = $urandom_range(0, 99) < 45;
      enq_packet.grid_slot = SLOT_W'($urandom_range(0, 6));
      enq_packet.ou_id = OU_W'($urandom_range(0, NUM_OUS - 1));
      flush = $urandom_range(0, 99) < 3;
      pr_ack = $urandom_range(0, 99) < 35;
      pr_done = !quiet && $urandom_range(0, 99) < 12;
      pr_error = !quiet && $urandom_range(0, 99) < 4;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
